wb_result_stage: RTL and testbench

//  Registered, parametrised writeback-result stage for the pipelined core; successor to the combinational 4:1 result mux.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_result_stage_load_fmt.sv | 47 ++++
 rtl/wb_result_stage.sv | 125 ++++++++++++
 tb/tb_wb_result_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback-stage source indices, load sizes and entry type
package wb_pkg;

  // Result-source indices; values above WB_SRC_IMM are user-defined sources
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MEM = 1;
  localparam int WB_SRC_PC4 = 2;
  localparam int WB_SRC_IMM = 3;

  // Load-size encodings
  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;
  localparam logic [1:0] LD_D = 2'b11;

  // Entry fields are sized for the widest supported build (XLEN<=64, RD_W<=8);
  // narrower builds zero-extend on entry and slice on exit.
  localparam int WB_XLEN_MAX = 64;
  localparam int WB_RD_W_MAX = 8;

  typedef struct packed {
    logic [WB_XLEN_MAX-1:0] result;
    logic [WB_RD_W_MAX-1:0] rd;
    logic                   we;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_stage_load_fmt.sv
// rtl/wb_result_stage_load_fmt.sv - wb_load_fmt: combinational load-data lane select, mask and extend
import wb_pkg::*;

module wb_load_fmt #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [2:0]      lane;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sbit;

  // Shift the addressed lane down, keep the sized field, then sign/zero extend
  always_comb begin
    lane    = (XLEN == 32) ? {1'b0, addr_lo[1:0]} : addr_lo;
    shifted = data >> {lane, 3'b000};
    mask    = XLEN'(32'hFFFF_FFFF);
    sbit    = shifted[31];
    case (size)
      LD_B: begin
        mask = XLEN'(8'hFF);
        sbit = shifted[7];
      end
      LD_H: begin
        mask = XLEN'(16'hFFFF);
        sbit = shifted[15];
      end
      LD_D: begin
        // dword only exists on 64-bit builds; 32-bit builds treat it as word
        if (XLEN == 64) begin
          mask = '1;
          sbit = shifted[XLEN-1];
        end
      end
      default: ;
    endcase
    result = shifted & mask;
    if (!ld_unsigned && sbit) result = result | ~mask;
  end

endmodule

// File: rtl/wb_result_stage.sv
// rtl/wb_result_stage.sv - registered writeback result stage with 2-entry skid (optional WB_BYPASS_EN forwarding ports)
import wb_pkg::*;

module wb_result_stage #(
  parameter  int XLEN  = 32,
  parameter  int NSRC  = 4,
  parameter  int RD_W  = 5,
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [NSRC*XLEN-1:0] in_data,
  input  logic [1:0]           in_ld_size,
  input  logic                 in_ld_unsigned,
  input  logic [2:0]           in_addr_lo,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_we,
`ifdef WB_BYPASS_EN
  output logic                 byp_valid,
  output logic [RD_W-1:0]      byp_rd,
  output logic [XLEN-1:0]      byp_data,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [RD_W-1:0]      out_rd,
  output logic                 out_we
);

  // Builds with fewer than two sources have no load path; point it at source 0
  localparam int MEM_IDX = (NSRC > WB_SRC_MEM) ? WB_SRC_MEM : 0;

  logic [XLEN-1:0] src_data;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] sel_result;
  logic            sel_ok;
  wb_entry_t       new_entry;

  wb_entry_t main_q, main_d;
  wb_entry_t skid_q, skid_d;
  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      unused_entry_bits;

  wb_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .data        (in_data[MEM_IDX*XLEN +: XLEN]),
    .size        (in_ld_size),
    .ld_unsigned (in_ld_unsigned),
    .addr_lo     (in_addr_lo),
    .result      (ld_data)
  );

  // Source mux; out-of-range selects give a zero result that never writes
  always_comb begin
    src_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SEL_W'(k)) src_data = in_data[k*XLEN +: XLEN];
    end
    sel_ok     = ({1'b0, in_sel} < (SEL_W+1)'(NSRC));
    sel_result = '0;
    if (sel_ok) sel_result = (in_sel == SEL_W'(WB_SRC_MEM)) ? ld_data : src_data;
    new_entry        = '0;
    new_entry.result = WB_XLEN_MAX'(sel_result);
    new_entry.rd     = WB_RD_W_MAX'(in_rd);
    new_entry.we     = in_we & sel_ok & (in_rd != '0);
  end

  // Main/skid control: main loads when free or draining, skid catches the rest
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // in_ready is low here, so no new input can arrive this cycle
      if (out_ready) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid) begin
      if (!main_valid_q || out_ready) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end else if (main_valid_q && out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready          = ~skid_valid_q;
  assign out_valid         = main_valid_q;
  assign out_result        = main_q.result[XLEN-1:0];
  assign out_rd            = main_q.rd[RD_W-1:0];
  assign out_we            = main_q.we;
  assign unused_entry_bits = ^main_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = main_valid_q & main_q.we;
  assign byp_rd    = main_q.rd[RD_W-1:0];
  assign byp_data  = main_q.result[XLEN-1:0];
`endif

endmodule

// File: tb/tb_wb_result_stage.sv
// tb/tb_wb_result_stage.sv - self-checking bench for wb_result_stage against a 2-deep FIFO reference
module tb_wb_result_stage;

  localparam int XLEN = 32;
  localparam int NSRC = 3;
  localparam int RD_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [NSRC*XLEN-1:0] in_data;
  logic [1:0]       in_ld_size;
  logic             in_ld_unsigned;
  logic [2:0]       in_addr_lo;
  logic [RD_W-1:0]  in_rd;
  logic             in_we;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_we;
`ifdef WB_BYPASS_EN
  logic             byp_valid;
  logic [RD_W-1:0]  byp_rd;
  logic [XLEN-1:0]  byp_data;
`endif

  wb_result_stage #(.XLEN(XLEN), .NSRC(NSRC), .RD_W(RD_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sel         (in_sel),
    .in_data        (in_data),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_addr_lo     (in_addr_lo),
    .in_rd          (in_rd),
    .in_we          (in_we),
`ifdef WB_BYPASS_EN
    .byp_valid      (byp_valid),
    .byp_rd         (byp_rd),
    .byp_data       (byp_data),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_we         (out_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   miscmp = 0;
  int   n_in = 0;
  int   dut_outs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected entry straight from the selection and load-format rules
  function automatic exp_t ref_entry();
    exp_t            e;
    longint unsigned v;
    longint          f;
    int              bits;
    e.we = in_we && (in_sel < NSRC) && (in_rd != 0);
    e.rd = in_rd;
    if (in_sel >= NSRC) e.res = 0;
    else if (in_sel != 1) e.res = in_data[in_sel*32 +: 32];
    else begin
      v = longint'(in_data[63:32]);
      v = v >> (8 * in_addr_lo[1:0]);
      bits = (in_ld_size == 2'd0) ? 8 : (in_ld_size == 2'd1) ? 16 : 32;
      if (bits == 32) e.res = v[31:0];
      else begin
        f = longint'(v % (longint'(1) << bits));
        if (!in_ld_unsigned && f >= (longint'(1) << (bits - 1))) f = f - (longint'(1) << bits);
        e.res = f[31:0];
      end
    end
    return e;
  endfunction

  // One clock: check outputs against the model, then advance the model
  task automatic cycle();
    exp_t e;
    bit   in_fire, out_fire;
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_we", out_we, q[0].we);
    end
`ifdef WB_BYPASS_EN
    chk("byp_valid", byp_valid, (q.size() > 0) && q[0].we);
    if (q.size() > 0) chk("byp_data", byp_data, q[0].res);
`endif
    if (out_valid && out_ready) dut_outs++;
    in_fire  = in_valid && (q.size() < 2);
    out_fire = out_ready && (q.size() > 0);
    e = ref_entry();
    @(posedge clk);
    if (out_fire) void'(q.pop_front());
    if (in_fire) begin
      q.push_back(e);
      n_in++;
    end
    #1;
  endtask

  task automatic set_in(input logic [1:0] sel, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [1:0] sz, input logic uns,
                        input logic [2:0] addr, input logic [4:0] rd, input logic we);
    in_valid       = 1'b1;
    in_sel         = sel;
    in_data        = {d2, d1, d0};
    in_ld_size     = sz;
    in_ld_unsigned = uns;
    in_addr_lo     = addr;
    in_rd          = rd;
    in_we          = we;
  endtask

  initial begin
    int base_in, base_out, cnt;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_data = '0; in_ld_size = '0; in_ld_unsigned = 1'b0;
    in_addr_lo = '0; in_rd = '0; in_we = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed selects and load formatting, downstream always ready
    out_ready = 1'b1;
    set_in(2'd0, 32'h0000000A, 32'h0, 32'h0, 2'b10, 1'b0, 3'd0, 5'd5, 1'b1);
    cycle();
    chk("alu_result", out_result, 32'h0000000A);
    chk("alu_we", out_we, 1);
    chk("alu_rd", out_rd, 5);
    set_in(2'd1, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 3'd1, 5'd7, 1'b1);
    cycle();
    chk("lb_signed", out_result, 32'hFFFFFFBE);
    set_in(2'd1, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 3'd1, 5'd7, 1'b1);
    cycle();
    chk("lb_unsigned", out_result, 32'h000000BE);
    set_in(2'd1, 32'h0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b0, 3'd2, 5'd7, 1'b1);
    cycle();
    chk("lh_signed", out_result, 32'hFFFFDEAD);
    set_in(2'd1, 32'h0, 32'hDEADBEEF, 32'h0, 2'b11, 1'b0, 3'd4, 5'd7, 1'b1);
    cycle();
    chk("ld_as_word", out_result, 32'hDEADBEEF);
    set_in(2'd2, 32'h0, 32'h0, 32'h00000004, 2'b10, 1'b0, 3'd0, 5'd0, 1'b1);
    cycle();
    chk("pc4_result", out_result, 32'h00000004);
    chk("rd0_we", out_we, 0);
    set_in(2'd3, 32'h11, 32'h22, 32'h33, 2'b10, 1'b0, 3'd0, 5'd9, 1'b1);
    cycle();
    chk("badsel_result", out_result, 0);
    chk("badsel_we", out_we, 0);
    in_valid = 1'b0;
    cycle();

    // Backpressure: only two entries fit while the output is stalled
    out_ready = 1'b0;
    base_in = n_in;
    for (int i = 0; i < 4; i++) begin
      set_in(2'd0, 32'h100 + (n_in - base_in), 32'h0, 32'h0, 2'b10, 1'b0, 3'd0,
             5'(1 + n_in - base_in), 1'b1);
      cycle();
    end
    chk("bp_accepted", n_in - base_in, 2);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    base_out = dut_outs;
    for (int i = 0; i < 20 && ((n_in - base_in) < 3 || q.size() > 0); i++) begin
      if ((n_in - base_in) < 3)
        set_in(2'd0, 32'h100 + (n_in - base_in), 32'h0, 32'h0, 2'b10, 1'b0, 3'd0,
               5'(1 + n_in - base_in), 1'b1);
      else in_valid = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("bp_all_accepted", n_in - base_in, 3);
    chk("bp_out_count", dut_outs - base_out, 3);

    // Streaming at full rate
    base_out = dut_outs;
    for (int i = 0; i < 8; i++) begin
      set_in(2'($urandom_range(0, 2)), $urandom, $urandom, $urandom, 2'($urandom),
             1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      cycle();
    end
    in_valid = 1'b0;
    cnt = dut_outs;
    cycle();
    chk("stream_last", dut_outs - cnt, 1);
    chk("stream_tput", dut_outs - base_out, 8);

    // Randomized handshake traffic
    for (int i = 0; i < 300; i++) begin
      set_in(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 2'($urandom),
             1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Asynchronous reset with the skid full
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 4 && q.size() < 2; i++) begin
      set_in(2'd0, 32'h55 + i, 32'h0, 32'h0, 2'b10, 1'b0, 3'd0, 5'd3, 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    chk("pre_rst_full", q.size(), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_we", out_we, 0);
    chk("async_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycle();
    set_in(2'd0, 32'h77, 32'h0, 32'h0, 2'b10, 1'b0, 3'd0, 5'd4, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
